// File: rtl/dcpu16_fetch_if.sv
// Instruction bus between the fetch stage (master) and program memory (slave).
// Read data travels on its own path into dcpu16_ctl and is not part of this bundle.
interface dcpu16_fetch_if;
  logic [15:0] f_adr;
  logic        f_stb;
  logic        f_ack;

  modport master (output f_adr, output f_stb, input f_ack);
  modport slave  (input f_adr, input f_stb, output f_ack);
endinterface

// File: rtl/dcpu16_fetch.sv
// DCPU-16 instruction-fetch stage: owns the PC, issues one bus read per instruction
// cycle, stalls the core until acknowledge or timeout, and flags discarded words via wpc.
module dcpu16_fetch #(
  parameter logic [15:0] RST_PC = 16'h0000,
  parameter int unsigned TMO    = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_run,
  input  logic [1:0]            i_pha,
  input  logic                  i_bra,
  input  logic                  i_bcc,
  input  logic [15:0]           i_bpc,
  input  logic                  i_skp,
  dcpu16_fetch_if.master        fbus,
  output logic                  o_ena,
  output logic                  o_wpc,
  output logic [15:0]           o_pc,
  output logic                  o_err
);

  localparam logic [15:0] TmoCnt = 16'(TMO);

  typedef enum logic {StIdle, StBusy} state_e;

  state_e      r_state;
  logic [15:0] r_pc;
  logic [15:0] r_adr;
  logic [15:0] r_cnt;
  logic        r_stb;
  logic        r_wpc;
  logic        r_err;

  logic w_busy;
  logic w_tmo_hit;
  logic w_issue;
  logic w_taken;

  assign w_busy    = (r_state == StBusy);
  assign w_tmo_hit = (r_cnt == TmoCnt);
  assign w_taken   = i_bra & i_bcc;

  // Stall only while a read is outstanding; a timeout releases the core in its final cycle.
  assign o_ena   = i_run & ~(w_busy & ~fbus.f_ack & ~w_tmo_hit);
  assign w_issue = ~w_busy & o_ena & (i_pha == 2'd1);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= StIdle;
      r_pc    <= RST_PC;
      r_adr   <= RST_PC;
      r_cnt   <= 16'd0;
      r_stb   <= 1'b0;
      r_wpc   <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_err <= 1'b0;
      case (r_state)
        StIdle: begin
          if (w_issue) begin
            r_state <= StBusy;
            r_stb   <= 1'b1;
            r_cnt   <= 16'd0;
            if (w_taken) begin
              r_adr <= i_bpc;
              r_pc  <= i_bpc;
              r_wpc <= 1'b0;
            end else begin
              // A skipped word is still fetched; wpc tells dcpu16_ctl to latch a NOP instead.
              r_adr <= r_pc;
              r_wpc <= i_skp;
            end
          end
        end
        StBusy: begin
          if (fbus.f_ack) begin
            r_state <= StIdle;
            r_stb   <= 1'b0;
            r_pc    <= r_adr + 16'd1;
            r_wpc   <= 1'b0;
          end else if (w_tmo_hit) begin
            // Abort: keep the PC on the failed word so the next cycle refetches it.
            r_state <= StIdle;
            r_stb   <= 1'b0;
            r_pc    <= r_adr;
            r_wpc   <= 1'b1;
            r_err   <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign fbus.f_adr = r_adr;
  assign fbus.f_stb = r_stb;
  assign o_wpc      = r_wpc;
  assign o_pc       = r_pc;
  assign o_err      = r_err;

endmodule

// File: tb/tb_dcpu16_fetch.sv
// Self-checking bench for dcpu16_fetch: directed scenarios plus randomized fetches
// checked against a PC/branch/skip model kept in the bench.
module tb_dcpu16_fetch;

  logic        clk;
  logic        rst;
  logic        run;
  logic [1:0]  pha;
  logic        bra;
  logic        bcc;
  logic [15:0] bpc;
  logic        skp;
  logic        ena;
  logic        wpc;
  logic [15:0] pc;
  logic        err;

  int checks   = 0;
  int failures = 0;

  // Model state: address the next untaken fetch will use.
  logic [15:0] m_pc;

  // Observations gathered by run_fetch.
  logic [15:0] ob_adr;
  logic        ob_wpc_iss;
  logic        ob_wpc_ack;
  logic        ob_wpc_after;
  logic        ob_stable;
  int          ob_ena_low;
  int          ob_stb_high;
  logic [15:0] ob_pc_after;
  logic        ob_err;

  dcpu16_fetch_if bus ();

  dcpu16_fetch #(
    .RST_PC (16'h0000),
    .TMO    (4)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .i_run (run),
    .i_pha (pha),
    .i_bra (bra),
    .i_bcc (bcc),
    .i_bpc (bpc),
    .i_skp (skp),
    .fbus  (bus),
    .o_ena (ena),
    .o_wpc (wpc),
    .o_pc  (pc),
    .o_err (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Stimulus only: one full instruction fetch from IDLE, recording what the DUT shows.
  task automatic run_fetch(input logic br, input logic bc, input logic [15:0] tgt,
                           input logic sk, input int waits);
    ob_ena_low  = 0;
    ob_stb_high = 0;
    ob_err      = 1'b0;
    ob_stable   = 1'b1;
    run = 1'b1; pha = 2'd1; bra = br; bcc = bc; bpc = tgt; skp = sk; bus.f_ack = 1'b0;
    @(posedge clk); #1;
    pha = 2'd2; bra = 1'b0; bcc = 1'b0; skp = 1'b0; bpc = 16'($urandom);
    ob_adr     = bus.f_adr;
    ob_wpc_iss = wpc;
    ob_err     = ob_err | err;
    for (int i = 0; i < waits; i++) begin
      @(negedge clk);
      if (!ena) ob_ena_low++;
      if (bus.f_stb) ob_stb_high++;
      if (bus.f_adr !== ob_adr) ob_stable = 1'b0;
      ob_err = ob_err | err;
      @(posedge clk); #1;
    end
    bus.f_ack = 1'b1;
    @(negedge clk);
    if (!ena) ob_ena_low++;
    if (bus.f_stb) ob_stb_high++;
    if (bus.f_adr !== ob_adr) ob_stable = 1'b0;
    ob_wpc_ack = wpc;
    ob_err     = ob_err | err;
    @(posedge clk); #1;
    bus.f_ack    = 1'b0;
    pha          = 2'd3;
    ob_pc_after  = pc;
    ob_wpc_after = wpc;
    ob_err       = ob_err | err;
  endtask

  task automatic test_reset();
    rst = 1'b1; run = 1'b0; pha = 2'd0; bra = 1'b0; bcc = 1'b0; bpc = 16'h0;
    skp = 1'b0; bus.f_ack = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (pc !== 16'h0000) begin failures++; $display("FAIL reset_pc got=%h want=0000", pc); end
    checks++; if (bus.f_adr !== 16'h0000) begin failures++; $display("FAIL reset_adr got=%h want=0000", bus.f_adr); end
    checks++; if (bus.f_stb !== 1'b0) begin failures++; $display("FAIL reset_stb got=%b want=0", bus.f_stb); end
    checks++; if (wpc !== 1'b0) begin failures++; $display("FAIL reset_wpc got=%b want=0", wpc); end
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b want=0", err); end
    rst = 1'b0;
    @(negedge clk);
    checks++; if (ena !== 1'b0) begin failures++; $display("FAIL reset_ena_run0 got=%b want=0", ena); end
    run = 1'b1;
    #1;
    checks++; if (ena !== 1'b1) begin failures++; $display("FAIL idle_ena_run1 got=%b want=1", ena); end
    @(posedge clk); #1;
    m_pc = 16'h0000;
  endtask

  task automatic test_sequential();
    for (int k = 0; k < 3; k++) begin
      run_fetch(1'b0, 1'b0, 16'h0, 1'b0, 1);
      checks++; if (ob_adr !== m_pc) begin failures++; $display("FAIL seq_adr%0d got=%h want=%h", k, ob_adr, m_pc); end
      checks++; if (ob_ena_low !== 1) begin failures++; $display("FAIL seq_ena_low%0d got=%0d want=1", k, ob_ena_low); end
      m_pc = m_pc + 16'd1;
    end
    checks++; if (pc !== 16'h0003) begin failures++; $display("FAIL seq_pc got=%h want=0003", pc); end
  endtask

  task automatic test_wrap();
    run_fetch(1'b1, 1'b1, 16'hFFFF, 1'b0, 2);
    checks++; if (ob_adr !== 16'hFFFF) begin failures++; $display("FAIL wrap_adr got=%h want=ffff", ob_adr); end
    checks++; if (ob_pc_after !== 16'h0000) begin failures++; $display("FAIL wrap_pc got=%h want=0000", ob_pc_after); end
    checks++; if (ob_err !== 1'b0) begin failures++; $display("FAIL wrap_err got=%b want=0", ob_err); end
    run_fetch(1'b0, 1'b0, 16'h0, 1'b0, 0);
    checks++; if (ob_adr !== 16'h0000) begin failures++; $display("FAIL wrap_next_adr got=%h want=0000", ob_adr); end
    m_pc = 16'h0001;
  endtask

  task automatic test_branch();
    run_fetch(1'b1, 1'b1, 16'h1234, 1'b0, 1);
    checks++; if (ob_adr !== 16'h1234) begin failures++; $display("FAIL br_adr got=%h want=1234", ob_adr); end
    checks++; if (ob_wpc_ack !== 1'b0) begin failures++; $display("FAIL br_wpc got=%b want=0", ob_wpc_ack); end
    run_fetch(1'b1, 1'b1, 16'h1234, 1'b1, 1);
    checks++; if (ob_adr !== 16'h1234) begin failures++; $display("FAIL brskp_adr got=%h want=1234", ob_adr); end
    checks++; if (ob_wpc_iss !== 1'b0) begin failures++; $display("FAIL brskp_wpc got=%b want=0", ob_wpc_iss); end
    m_pc = 16'h1235;
    run_fetch(1'b1, 1'b0, 16'h4321, 1'b0, 0);
    checks++; if (ob_adr !== m_pc) begin failures++; $display("FAIL br_nottaken_adr got=%h want=%h", ob_adr, m_pc); end
    m_pc = m_pc + 16'd1;
    run_fetch(1'b0, 1'b1, 16'h4321, 1'b0, 0);
    checks++; if (ob_adr !== m_pc) begin failures++; $display("FAIL bcc_only_adr got=%h want=%h", ob_adr, m_pc); end
    m_pc = m_pc + 16'd1;
  endtask

  task automatic test_skip();
    run_fetch(1'b1, 1'b1, 16'h000F, 1'b0, 0);
    run_fetch(1'b0, 1'b0, 16'h0, 1'b1, 2);
    checks++; if (ob_adr !== 16'h0010) begin failures++; $display("FAIL skp_adr got=%h want=0010", ob_adr); end
    checks++; if (ob_wpc_ack !== 1'b1) begin failures++; $display("FAIL skp_wpc_latch got=%b want=1", ob_wpc_ack); end
    checks++; if (ob_pc_after !== 16'h0011) begin failures++; $display("FAIL skp_pc got=%h want=0011", ob_pc_after); end
    checks++; if (ob_wpc_after !== 1'b0) begin failures++; $display("FAIL skp_wpc_clear got=%b want=0", ob_wpc_after); end
    run_fetch(1'b0, 1'b0, 16'h0, 1'b0, 1);
    checks++; if (ob_adr !== 16'h0011) begin failures++; $display("FAIL skp_next_adr got=%h want=0011", ob_adr); end
    checks++; if (ob_wpc_ack !== 1'b0) begin failures++; $display("FAIL skp_next_wpc got=%b want=0", ob_wpc_ack); end
    m_pc = 16'h0012;
  endtask

  task automatic test_idle_ack();
    pha = 2'd0; bus.f_ack = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    bus.f_ack = 1'b0;
    checks++; if (pc !== m_pc) begin failures++; $display("FAIL idle_ack_pc got=%h want=%h", pc, m_pc); end
    checks++; if (bus.f_stb !== 1'b0) begin failures++; $display("FAIL idle_ack_stb got=%b want=0", bus.f_stb); end
    run_fetch(1'b0, 1'b0, 16'h0, 1'b0, 1);
    checks++; if (ob_adr !== m_pc) begin failures++; $display("FAIL idle_ack_next got=%h want=%h", ob_adr, m_pc); end
    m_pc = m_pc + 16'd1;
  endtask

  task automatic test_run_low();
    logic saw_stb;
    logic saw_ena;
    saw_stb = 1'b0; saw_ena = 1'b0;
    run = 1'b0; pha = 2'd1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (ena) saw_ena = 1'b1;
      @(posedge clk); #1;
      if (bus.f_stb) saw_stb = 1'b1;
    end
    checks++; if (saw_stb !== 1'b0) begin failures++; $display("FAIL runlow_idle_stb got=%b want=0", saw_stb); end
    checks++; if (saw_ena !== 1'b0) begin failures++; $display("FAIL runlow_idle_ena got=%b want=0", saw_ena); end
    checks++; if (pc !== m_pc) begin failures++; $display("FAIL runlow_idle_pc got=%h want=%h", pc, m_pc); end
    run = 1'b1;
    @(posedge clk); #1;
    pha = 2'd2; run = 1'b0;
    saw_stb = 1'b1; saw_ena = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      if (ena) saw_ena = 1'b1;
      if (!bus.f_stb) saw_stb = 1'b0;
      @(posedge clk); #1;
    end
    checks++; if (saw_stb !== 1'b1) begin failures++; $display("FAIL runlow_busy_stb got=%b want=1", saw_stb); end
    bus.f_ack = 1'b1;
    @(negedge clk);
    if (ena) saw_ena = 1'b1;
    checks++; if (saw_ena !== 1'b0) begin failures++; $display("FAIL runlow_busy_ena got=%b want=0", saw_ena); end
    @(posedge clk); #1;
    bus.f_ack = 1'b0;
    m_pc = m_pc + 16'd1;
    checks++; if (pc !== m_pc) begin failures++; $display("FAIL runlow_ack_pc got=%h want=%h", pc, m_pc); end
    checks++; if (bus.f_stb !== 1'b0) begin failures++; $display("FAIL runlow_ack_stb got=%b want=0", bus.f_stb); end
    run = 1'b1; pha = 2'd3;
  endtask

  task automatic test_timeout();
    int hi;
    run = 1'b1; pha = 2'd1; bus.f_ack = 1'b0;
    @(posedge clk); #1;
    pha = 2'd2;
    hi = 0;
    if (bus.f_stb) hi++;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (!bus.f_stb) break;
      hi++;
    end
    checks++; if (hi !== 5) begin failures++; $display("FAIL tmo_stb_cycles got=%0d want=5", hi); end
    checks++; if (err !== 1'b1) begin failures++; $display("FAIL tmo_err got=%b want=1", err); end
    checks++; if (wpc !== 1'b1) begin failures++; $display("FAIL tmo_wpc got=%b want=1", wpc); end
    checks++; if (pc !== m_pc) begin failures++; $display("FAIL tmo_pc got=%h want=%h", pc, m_pc); end
    checks++; if (ena !== 1'b1) begin failures++; $display("FAIL tmo_ena got=%b want=1", ena); end
    @(posedge clk); #1;
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL tmo_err_pulse got=%b want=0", err); end
    run_fetch(1'b0, 1'b0, 16'h0, 1'b0, 1);
    checks++; if (ob_adr !== m_pc) begin failures++; $display("FAIL tmo_refetch got=%h want=%h", ob_adr, m_pc); end
    checks++; if (ob_wpc_ack !== 1'b0) begin failures++; $display("FAIL tmo_refetch_wpc got=%b want=0", ob_wpc_ack); end
    m_pc = m_pc + 16'd1;
  endtask

  task automatic test_reset_mid();
    run = 1'b1; pha = 2'd1; bus.f_ack = 1'b0;
    @(posedge clk); #1;
    pha = 2'd2;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; pha = 2'd3;
    checks++; if (bus.f_stb !== 1'b0) begin failures++; $display("FAIL rstmid_stb got=%b want=0", bus.f_stb); end
    checks++; if (pc !== 16'h0000) begin failures++; $display("FAIL rstmid_pc got=%h want=0000", pc); end
    bus.f_ack = 1'b1;
    @(posedge clk); #1;
    bus.f_ack = 1'b0;
    checks++; if (pc !== 16'h0000) begin failures++; $display("FAIL rstmid_lateack_pc got=%h want=0000", pc); end
    checks++; if (bus.f_stb !== 1'b0) begin failures++; $display("FAIL rstmid_lateack_stb got=%b want=0", bus.f_stb); end
    run_fetch(1'b0, 1'b0, 16'h0, 1'b0, 0);
    checks++; if (ob_adr !== 16'h0000) begin failures++; $display("FAIL rstmid_first got=%h want=0000", ob_adr); end
    m_pc = 16'h0001;
  endtask

  task automatic test_random();
    logic        br;
    logic        bc;
    logic        sk;
    logic [15:0] tgt;
    int          waits;
    logic [15:0] exp_adr;
    logic        exp_wpc;
    for (int n = 0; n < 150; n++) begin
      br    = 1'($urandom_range(0, 1));
      bc    = 1'($urandom_range(0, 1));
      sk    = ($urandom_range(0, 3) == 0);
      tgt   = 16'($urandom);
      waits = int'($urandom_range(0, 3));
      if (br && bc) begin
        exp_adr = tgt;
        exp_wpc = 1'b0;
      end else begin
        exp_adr = m_pc;
        exp_wpc = sk;
      end
      run_fetch(br, bc, tgt, sk, waits);
      checks++; if (ob_adr !== exp_adr) begin failures++; $display("FAIL rnd_adr n=%0d got=%h want=%h", n, ob_adr, exp_adr); end
      checks++; if (ob_stable !== 1'b1) begin failures++; $display("FAIL rnd_adr_stable n=%0d got=%b want=1", n, ob_stable); end
      checks++; if (ob_wpc_ack !== exp_wpc) begin failures++; $display("FAIL rnd_wpc n=%0d got=%b want=%b", n, ob_wpc_ack, exp_wpc); end
      checks++; if (ob_wpc_after !== 1'b0) begin failures++; $display("FAIL rnd_wpc_clear n=%0d got=%b want=0", n, ob_wpc_after); end
      checks++; if (ob_ena_low !== waits) begin failures++; $display("FAIL rnd_ena_low n=%0d got=%0d want=%0d", n, ob_ena_low, waits); end
      checks++; if (ob_stb_high !== waits + 1) begin failures++; $display("FAIL rnd_stb_high n=%0d got=%0d want=%0d", n, ob_stb_high, waits + 1); end
      m_pc = exp_adr + 16'd1;
      checks++; if (ob_pc_after !== m_pc) begin failures++; $display("FAIL rnd_pc n=%0d got=%h want=%h", n, ob_pc_after, m_pc); end
      checks++; if (ob_err !== 1'b0) begin failures++; $display("FAIL rnd_err n=%0d got=%b want=0", n, ob_err); end
    end
  endtask

  initial begin
    m_pc = 16'h0000;
    test_reset();
    test_sequential();
    test_wrap();
    test_branch();
    test_skip();
    test_idle_ack();
    test_run_low();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
